// File: rtl/camera_dma_wr_if.sv
// camera_dma_wr_if: AHB-Lite write-master signal bundle between the camera DMA and the system bus.
interface camera_dma_wr_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, input HREADY, HRESP);
  modport slave (input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, output HREADY, HRESP);
endinterface

// File: rtl/camera_dma_wr.sv
// camera_dma_wr: pops 128-bit capture FIFO entries and writes each as an AHB-Lite INCR4 burst into a circular zone.
// Define CAMDMA_BYTESWAP_EN to byte-reverse every HWDATA word for big-endian consumers.
module camera_dma_wr #(
  parameter int FRMCNT_W = 8,
  parameter int ZONE_W = 20
) (
  input  logic                HCLK,
  input  logic                HReset_N,
  input  logic                DmaEn,
  input  logic [31:0]         ZoneBase,
  input  logic [ZONE_W-1:0]   ZoneSize,
  input  logic                i_FIFOEmpty,
  output logic                o_ReadEn,
  input  logic [127:0]        i_RdData,
  input  logic                i_ZONE_ReStart,
  camera_dma_wr_if.master     ahb,
  output logic [31:0]         o_WrPtr,
  output logic [FRMCNT_W-1:0] o_FrameCnt,
  output logic                o_BusErr,
  output logic                o_Busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DLAST, ERR} state_t;
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  state_t st, stNext;
  logic [1:0] beat, beatNext, dataBeat, trans;
  logic [127:0] entryBuf;
  logic [ZONE_W-1:0] offset, zoneLen, nextOff;
  logic [31:0] zoneBase, word;
  logic dataPhase, pending, readEn, done, errNow, wrap, active;
  // Offsets are kept relative to the zone so the wrap test is independent of the base address.
  assign zoneBase = ZoneBase & ~32'hF;
  assign zoneLen = ((ZoneSize & ~ZONE_W'(15)) == '0) ? ZONE_W'(16) : (ZoneSize & ~ZONE_W'(15));
  assign nextOff = offset + ZONE_W'(16);
  assign wrap = nextOff == zoneLen;
  assign errNow = dataPhase & ahb.HRESP & ~ahb.HREADY;
  always_comb begin
    stNext = st;
    beatNext = beat;
    readEn = 1'b0;
    done = 1'b0;
    trans = T_IDLE;
    case (st)
      IDLE: begin
        if (!pending && DmaEn && !i_FIFOEmpty) begin
          readEn = 1'b1;
          stNext = ADDR;
          beatNext = 2'd0;
        end
      end
      ADDR: begin
        if (errNow) stNext = ERR;
        else begin
          trans = (beat == 2'd0) ? T_NONSEQ : T_SEQ;
          if (ahb.HREADY) begin
            beatNext = beat + 2'd1;
            stNext = (beat == 2'd3) ? DLAST : ADDR;
          end
        end
      end
      DLAST: begin
        if (errNow) stNext = ERR;
        else if (ahb.HREADY) begin
          done = 1'b1;
          stNext = IDLE;
        end
      end
      ERR: begin
        if (ahb.HREADY) begin
          done = 1'b1;
          stNext = IDLE;
        end
      end
      default: stNext = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      st <= IDLE;
      beat <= '0;
      dataBeat <= '0;
      dataPhase <= 1'b0;
      entryBuf <= '0;
      o_WrPtr <= '0;
      offset <= '0;
      o_FrameCnt <= '0;
      o_BusErr <= 1'b0;
      pending <= 1'b0;
    end else begin
      st <= stNext;
      beat <= beatNext;
      if (readEn) entryBuf <= i_RdData;
      if (ahb.HREADY) begin
        dataPhase <= trans != T_IDLE;
        dataBeat <= beat;
      end
      o_BusErr <= (o_BusErr & DmaEn) | errNow;
      pending <= i_ZONE_ReStart | (pending & (st != IDLE));
      if (st == IDLE && pending) begin
        o_WrPtr <= zoneBase;
        offset <= '0;
        o_FrameCnt <= o_FrameCnt + FRMCNT_W'(1);
      end else if (done) begin
        o_WrPtr <= wrap ? zoneBase : o_WrPtr + 32'd16;
        offset <= wrap ? '0 : nextOff;
      end
    end
  end
  assign word = entryBuf[{dataBeat, 5'd0} +: 32];
  assign active = trans != T_IDLE;
  assign o_ReadEn = readEn & HReset_N;
  assign o_Busy = st != IDLE;
  assign ahb.HTRANS = trans;
  assign ahb.HADDR = o_WrPtr + {28'd0, beat, 2'b00};
  assign ahb.HWRITE = active;
  assign ahb.HSIZE = active ? 3'b010 : 3'b000;
  assign ahb.HBURST = active ? 3'b011 : 3'b000;
`ifdef CAMDMA_BYTESWAP_EN
  assign ahb.HWDATA = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
  assign ahb.HWDATA = word;
`endif
endmodule

// File: tb/tb_camera_dma_wr.sv
// tb_camera_dma_wr: randomized scoreboard bench with a burst-level zone model and a reactive AHB slave.
module tb_camera_dma_wr;
  localparam int ZW = 20;
  logic HCLK = 1'b0, HReset_N = 1'b0, DmaEn = 1'b0, i_FIFOEmpty = 1'b1, i_ZONE_ReStart = 1'b0;
  logic [31:0] ZoneBase = '0;
  logic [ZW-1:0] ZoneSize = '0;
  logic [127:0] i_RdData = '0;
  logic o_ReadEn, o_BusErr, o_Busy;
  logic [31:0] o_WrPtr;
  logic [7:0] o_FrameCnt;
  camera_dma_wr_if ahb();
  always #5 HCLK = ~HCLK;
  camera_dma_wr #(.FRMCNT_W(8), .ZONE_W(ZW)) dut (
    .HCLK(HCLK), .HReset_N(HReset_N), .DmaEn(DmaEn), .ZoneBase(ZoneBase), .ZoneSize(ZoneSize),
    .i_FIFOEmpty(i_FIFOEmpty), .o_ReadEn(o_ReadEn), .i_RdData(i_RdData), .i_ZONE_ReStart(i_ZONE_ReStart),
    .ahb(ahb), .o_WrPtr(o_WrPtr), .o_FrameCnt(o_FrameCnt), .o_BusErr(o_BusErr), .o_Busy(o_Busy)
  );
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [1:0] beat;} beat_t;
  int checks = 0, errors = 0, popCnt = 0, cyc = 0, popCyc = 0, errPhase = 0, stallLeft = 0;
  logic [127:0] fifo[$];
  beat_t expQ[$];
  beat_t dataExp;
  bit dataPending = 0, waitRand = 0, gapRand = 0, errArm = 0, stallArm = 0, prevStall = 0;
  logic [31:0] pAddr, pData;
  logic [1:0] pTrans;
  logic [31:0] mPtr = '0;
  int mOff = 0;
  logic [7:0] mFrame = '0;
  bit mPending = 0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef CAMDMA_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Zone model: a restart takes effect before the next burst; each burst advances 16 bytes, wrapping at the rounded size.
  function automatic void applyPending();
    if (mPending) begin
      mPtr = ZoneBase & ~32'hF;
      mOff = 0;
      mFrame++;
      mPending = 0;
    end
  endfunction

  function automatic void modelPop(input logic [127:0] e);
    int len;
    applyPending();
    for (int k = 0; k < 4; k++) expQ.push_back('{a: mPtr + 32'(4 * k), d: e[32 * k +: 32], beat: 2'(k)});
    len = int'(ZoneSize) / 16 * 16;
    if (len == 0) len = 16;
    mOff += 16;
    if (mOff == len) begin
      mOff = 0;
      mPtr = ZoneBase & ~32'hF;
    end else mPtr += 32'd16;
  endfunction

  // FIFO + AHB slave driver, with the scoreboard monitor sampling half a cycle before each active edge.
  initial begin
    beat_t e;
    ahb.HREADY = 1'b1;
    ahb.HRESP = 1'b0;
    forever begin
      @(negedge HCLK);
      cyc++;
      i_FIFOEmpty = fifo.size() == 0 || (gapRand && $urandom_range(0, 3) == 0);
      i_RdData = fifo.size() != 0 ? fifo[0] : '0;
      if (errPhase == 1) begin
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b1; errPhase = 2;
      end else if (errArm && dataPending && dataExp.beat == 2'd1) begin
        ahb.HREADY = 1'b0; ahb.HRESP = 1'b1; errPhase = 1; errArm = 0;
      end else if (stallLeft > 0) begin
        ahb.HREADY = 1'b0; ahb.HRESP = 1'b0; stallLeft--;
      end else if (stallArm && dataPending && dataExp.beat == 2'd2) begin
        ahb.HREADY = 1'b0; ahb.HRESP = 1'b0; stallLeft = 2; stallArm = 0;
      end else begin
        ahb.HREADY = !(waitRand && dataPending && $urandom_range(0, 2) == 0);
        ahb.HRESP = 1'b0;
      end
      #1;
      if (o_ReadEn) begin
        check("pop_while_empty", i_FIFOEmpty, 0);
        if (fifo.size() != 0) modelPop(fifo.pop_front());
        popCnt++;
        popCyc = cyc;
      end
      if (errPhase == 1) check("err_htrans_idle", ahb.HTRANS, 2'b00);
      if (prevStall && !ahb.HRESP) begin
        check("stall_htrans_hold", ahb.HTRANS, pTrans);
        if (pTrans != 2'b00) check("stall_haddr_hold", ahb.HADDR, pAddr);
        if (dataPending) check("stall_hwdata_hold", ahb.HWDATA, pData);
      end
      if (ahb.HREADY) begin
        if (dataPending && !ahb.HRESP) check("hwdata", ahb.HWDATA, sw(dataExp.d));
        if (errPhase == 2) begin
          check("err_dropped_beats", expQ.size(), 2);
          expQ.delete();
          errPhase = 0;
        end
        dataPending = 0;
        if (ahb.HTRANS != 2'b00) begin
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_addr: HADDR=%h HTRANS=%b with no beat expected", ahb.HADDR, ahb.HTRANS);
          end else begin
            e = expQ.pop_front();
            check("haddr", ahb.HADDR, e.a);
            check("htrans", ahb.HTRANS, e.beat == 2'd0 ? 2'b10 : 2'b11);
            check("hctrl", {ahb.HWRITE, ahb.HSIZE, ahb.HBURST}, 7'b1_010_011);
            if (e.beat == 2'd0) check("pop_to_addr_latency", cyc - popCyc, 1);
            dataPending = 1;
            dataExp = e;
          end
        end
      end
      prevStall = !ahb.HREADY && !ahb.HRESP;
      pTrans = ahb.HTRANS;
      pAddr = ahb.HADDR;
      pData = ahb.HWDATA;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #2;
  endtask

  task automatic restart();
    i_ZONE_ReStart = 1'b1;
    mPending = 1;
    tick(1);
    i_ZONE_ReStart = 1'b0;
  endtask

  task automatic waitIdle(input int n);
    int i = 0;
    while ((fifo.size() != 0 || expQ.size() != 0 || o_Busy || dataPending) && i < n) begin
      tick(1);
      i++;
    end
    tick(3);
    check("idle_timeout", i >= n, 0);
  endtask

  task automatic checkpoint();
    waitIdle(400);
    applyPending();
    check("wrptr", o_WrPtr, mPtr);
    check("framecnt", o_FrameCnt, mFrame);
    check("busy_idle", o_Busy, 0);
  endtask

  initial begin
    int p0, i;
    logic [31:0] ptrBefore;
    tick(3);
    check("rst_htrans", ahb.HTRANS, 2'b00);
    check("rst_ctrl", {ahb.HWRITE, ahb.HSIZE, ahb.HBURST}, 0);
    check("rst_outs", {o_ReadEn, o_BusErr, o_Busy, o_FrameCnt, o_WrPtr}, 0);
    HReset_N = 1'b1;
    ZoneBase = 32'h2000_0000;
    ZoneSize = ZW'('h40);
    DmaEn = 1'b1;
    tick(2);
    restart();
    checkpoint();
    check("restart_base", o_WrPtr, 32'h2000_0000);
    fifo.push_back(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    checkpoint();
    check("single_ptr", o_WrPtr, 32'h2000_0010);
    restart();
    p0 = popCnt;
    for (int k = 0; k < 5; k++) fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    checkpoint();
    check("five_pops", popCnt - p0, 5);
    stallArm = 1;
    fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    checkpoint();
    check("stall_done", stallArm, 0);
    check("stall_ptr", o_WrPtr, 32'h2000_0020);
    fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    i = 0;
    while (ahb.HTRANS != 2'b11 && i < 50) begin tick(1); i++; end
    check("beat1_seen", i >= 50, 0);
    restart();
    checkpoint();
    check("midrestart_ptr", o_WrPtr, 32'h2000_0000);
    check("midrestart_frame", o_FrameCnt, 8'd3);
    errArm = 1;
    ptrBefore = mPtr;
    fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    checkpoint();
    check("err_ptr", o_WrPtr, ptrBefore + 32'd16);
    check("err_sticky", o_BusErr, 1);
    tick(5);
    check("err_held", o_BusErr, 1);
    DmaEn = 1'b0;
    tick(2);
    check("err_cleared", o_BusErr, 0);
    DmaEn = 1'b1;
    p0 = popCnt;
    fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    i = 0;
    while (popCnt == p0 && i < 50) begin tick(1); i++; end
    DmaEn = 1'b0;
    tick(20);
    check("dmaen_off_pops", popCnt - p0, 1);
    check("dmaen_off_left", fifo.size(), 1);
    DmaEn = 1'b1;
    checkpoint();
    waitRand = 1;
    gapRand = 1;
    for (int r = 0; r < 4; r++) begin
      ZoneBase = $urandom;
      ZoneSize = ZW'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      restart();
      for (int k = 0; k < 12; k++) fifo.push_back({$urandom, $urandom, $urandom, $urandom});
      checkpoint();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/camera_dma_wr.md
Name: camera_dma_wr

Overview:
- Downstream consumer of the camera capture receive queue, in the HCLK domain.
- Pops 128-bit entries from the capture FIFO and writes each one to memory as a 4-beat INCR4 AHB-Lite write burst.
- Writes into a circular frame-buffer zone.
- Re-arms the write pointer to the zone base on the capture stage's zone-restart pulse, and reports frame count, bus error and current pointer.

Parameters:
- FRMCNT_W, 8: width of the frame counter.
- ZONE_W, 20: width of ZoneSize in bytes; max zone size is 2^ZONE_W - 16.

Ports:
- HCLK in 1: system clock; the only clock.
- HReset_N in 1: reset, asynchronous assert, active-low.
- DmaEn in 1: enable from register block.
- ZoneBase in 32: zone start byte address; bits [3:0] ignored and treated as 0.
- ZoneSize in ZONE_W: zone length in bytes; bits [3:0] ignored; 0 means 16 bytes.
- i_FIFOEmpty in 1: capture FIFO empty.
- o_ReadEn out 1: FIFO pop, one cycle.
- i_RdData in 128: FIFO head data, combinational; valid while i_FIFOEmpty=0.
- i_ZONE_ReStart in 1: one-cycle frame-start pulse.
- HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HWDATA out 32: AHB-Lite master outputs.
- HREADY in 1, HRESP in 1: AHB-Lite slave response.
- o_WrPtr out 32: next burst address.
- o_FrameCnt out FRMCNT_W: restart count, wraps.
- o_BusErr out 1: sticky error flag.
- o_Busy out 1: state != IDLE.

Behaviour:
- Reset values: all outputs 0, HTRANS=IDLE(2'b00), state IDLE, restart-pending flag 0.
- Constant outputs: HWRITE=1, HSIZE=3'b010, HBURST=3'b011 (INCR4) whenever HTRANS != IDLE.
- FSM states: IDLE, ADDR, DLAST, ERR.
- IDLE, restart handling:
  - If restart is pending: o_WrPtr<=ZoneBase&~0xF and o_FrameCnt++, then clear pending.
  - This takes precedence over popping in the same cycle.
- IDLE, pop:
  - Else if DmaEn & ~i_FIFOEmpty: o_ReadEn=1 for exactly one cycle and i_RdData is latched into the 128-bit buffer in that same cycle.
  - Next state ADDR with beat index 0.
- ADDR:
  - HADDR=o_WrPtr+4*beat.
  - HTRANS=NONSEQ for beat 0, SEQ for beats 1..3.
  - On HREADY, beat index advances.
  - HWDATA for beat k is buffer word k (bits 32k+31:32k), driven in the cycle after address phase k is accepted and held until HREADY.
  - After beat 3's address is accepted: HTRANS=IDLE, go to DLAST.
- DLAST:
  - Wait for HREADY on beat 3's data phase.
  - Then o_WrPtr += 16; if the new offset equals ZoneSize (rounded), wrap to base.
  - Return to IDLE.
- Pop-to-first-address latency: 1 cycle. With zero wait states, a burst completes 6 cycles after pop.
- Error response:
  - HRESP=1 with HREADY=0 in any data phase: drive HTRANS=IDLE in that cycle.
  - Set o_BusErr, go to ERR.
  - ERR waits for the HREADY=1 completion cycle, then drops remaining beats.
  - The pointer advances by 16 anyway (the entry is discarded) and the FSM returns to IDLE.
- o_BusErr clears only when DmaEn=0.
- i_ZONE_ReStart:
  - Always sets the pending flag; it is never lost.
  - A pulse arriving mid-burst is applied at the next IDLE, after the burst completes.
  - Two pulses before that IDLE increment o_FrameCnt only once.
- DmaEn deasserted mid-burst: the burst finishes normally; no new pop. DmaEn=0 does not block restart handling.
- FIFO empty: no pop. o_ReadEn is never asserted while i_FIFOEmpty=1.
- Reset mid-burst: the bus returns to IDLE immediately (asynchronous).
- Pointer arithmetic: modulo 2^32. The offset counter is ZONE_W bits.

Optional Feature:
- Macro: CAMDMA_BYTESWAP_EN.
- Defined: each HWDATA word is byte-reversed ({b0,b1,b2,b3}), for big-endian pixel consumers.
- Undefined: words pass unchanged, with byte 0 = HWDATA[7:0].

Test Plan:
- Base=0x2000_0000, Size=0x40, one FIFO entry 0x0F0E..0100, HREADY=1:
  - HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x..00,04,08,0C.
  - HWDATA 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - o_WrPtr=0x2000_0010.
- Five entries with Size=0x40: fifth burst starts at 0x2000_0000 (wrap); o_ReadEn pulsed exactly 5 times.
- HREADY low for 3 cycles on beat 2's data phase: HWDATA and HADDR held stable; burst completes; pointer +16.
- i_ZONE_ReStart during beat 1 with o_WrPtr=0x2000_0020: burst finishes at 0x20-0x2C, then o_WrPtr=0x2000_0000 and o_FrameCnt=1, before the next pop.
- HRESP error on beat 1: HTRANS IDLE in the first error cycle, no beat 2/3, o_BusErr=1 until DmaEn=0, pointer +16.
- Build with CAMDMA_BYTESWAP_EN defined, entry as in scenario 1: first HWDATA=0x00010203.
